ray_tri_scheduler: RTL and testbench

Sequences the combinational intersect datapath over a list of triangles for one ray at a time. Accepts a ray job, fetches triangles one at a time from triangle memory, and presents each triangle and the held ray to the intersect unit. It registers the unit's verdict and keeps the nearest valid hit. When the list is exhausted it returns one result record per job through a valid/ready handshake.

---
 rtl/ray_tri_scheduler_if.sv | 57 +++++
 rtl/ray_tri_scheduler.sv | 175 +++++++++++++++++
 tb/tb_ray_tri_scheduler.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ray_tri_scheduler_if.sv
// Job / triangle-memory / intersect-unit / result bus of the ray-triangle scheduler.
// Ports (slave = scheduler side):
//   job     : i_ray_valid, o_ray_ready, i_ray, i_num_tris, i_base_addr, i_abort
//   memory  : o_tri_req, o_tri_addr, i_tri_valid, i_tri
//   isect   : o_isect_ray, o_isect_tri, i_isect_result, i_isect_invalid, i_isect_t
//   result  : o_res_valid, i_res_ready, o_hit, o_hit_idx, o_hit_t, o_any_invalid
// Vector lanes are packed as [vertex][axis][32-bit fixed point].
interface ray_tri_scheduler_if #(
    parameter int unsigned IDX_W  = 16,
    parameter int unsigned ADDR_W = 20
);
    // job
    logic                      i_ray_valid;
    logic                      o_ray_ready;
    logic [1:0][2:0][31:0]     i_ray;
    logic [IDX_W-1:0]          i_num_tris;
    logic [ADDR_W-1:0]         i_base_addr;
    logic                      i_abort;
    // triangle memory
    logic                      o_tri_req;
    logic [ADDR_W-1:0]         o_tri_addr;
    logic                      i_tri_valid;
    logic [2:0][2:0][31:0]     i_tri;
    // intersect unit
    logic [1:0][2:0][31:0]     o_isect_ray;
    logic [2:0][2:0][31:0]     o_isect_tri;
    logic                      i_isect_result;
    logic                      i_isect_invalid;
    logic signed [31:0]        i_isect_t;
    // result record
    logic                      o_res_valid;
    logic                      i_res_ready;
    logic                      o_hit;
    logic [IDX_W-1:0]          o_hit_idx;
    logic signed [31:0]        o_hit_t;
    logic                      o_any_invalid;

    modport slave (
        input  i_ray_valid, i_ray, i_num_tris, i_base_addr, i_abort,
        input  i_tri_valid, i_tri,
        input  i_isect_result, i_isect_invalid, i_isect_t,
        input  i_res_ready,
        output o_ray_ready, o_tri_req, o_tri_addr,
        output o_isect_ray, o_isect_tri,
        output o_res_valid, o_hit, o_hit_idx, o_hit_t, o_any_invalid
    );

    modport master (
        output i_ray_valid, i_ray, i_num_tris, i_base_addr, i_abort,
        output i_tri_valid, i_tri,
        output i_isect_result, i_isect_invalid, i_isect_t,
        output i_res_ready,
        input  o_ray_ready, o_tri_req, o_tri_addr,
        input  o_isect_ray, o_isect_tri,
        input  o_res_valid, o_hit, o_hit_idx, o_hit_t, o_any_invalid
    );
endinterface

// File: rtl/ray_tri_scheduler.sv
// Walks a triangle list for one ray: fetches each triangle, presents it with the
// held ray to the combinational intersect unit, keeps the nearest valid hit and
// returns one result record per job over a valid/ready handshake.
// Ports:
//   i_clk  : clock, rising edge
//   i_rstn : asynchronous active-low reset
//   bus    : ray_tri_scheduler_if.slave (job, memory, intersect, result groups)
// All bus outputs are registered.
module ray_tri_scheduler #(
    parameter int unsigned IDX_W  = 16,
    parameter int unsigned ADDR_W = 20
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    ray_tri_scheduler_if.slave    bus
);

    localparam int unsigned T_W = 32;
    localparam logic signed [T_W-1:0] T_MAX = 32'sh7FFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_TEST,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        num_q, num_d;
    logic [ADDR_W-1:0]       base_q, base_d;
    logic [IDX_W-1:0]        idx_q, idx_d;

    logic [1:0][2:0][31:0]   ray_d;
    logic [2:0][2:0][31:0]   tri_d;
    logic [ADDR_W-1:0]       addr_d;
    logic                    tri_req_d;
    logic                    ready_d;
    logic                    res_valid_d;
    logic                    hit_d;
    logic [IDX_W-1:0]        hit_idx_d;
    logic signed [T_W-1:0]   hit_t_d;
    logic                    any_inv_d;

    logic [IDX_W-1:0]        idx_inc;
    logic [IDX_W-1:0]        idx_last;
    logic                    closer;

    assign idx_inc  = idx_q + IDX_W'(1);
    assign idx_last = num_q - IDX_W'(1);
    // o_hit_t doubles as the running best distance; strict compare keeps the lower index on ties
    assign closer   = bus.i_isect_result && (bus.i_isect_t < bus.o_hit_t);

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q           <= S_IDLE;
            num_q             <= '0;
            base_q            <= '0;
            idx_q             <= '0;
            bus.o_isect_ray   <= '0;
            bus.o_isect_tri   <= '0;
            bus.o_tri_addr    <= '0;
            bus.o_tri_req     <= 1'b0;
            bus.o_ray_ready   <= 1'b1;
            bus.o_res_valid   <= 1'b0;
            bus.o_hit         <= 1'b0;
            bus.o_hit_idx     <= '0;
            bus.o_hit_t       <= T_MAX;
            bus.o_any_invalid <= 1'b0;
        end else begin
            state_q           <= state_d;
            num_q             <= num_d;
            base_q            <= base_d;
            idx_q             <= idx_d;
            bus.o_isect_ray   <= ray_d;
            bus.o_isect_tri   <= tri_d;
            bus.o_tri_addr    <= addr_d;
            bus.o_tri_req     <= tri_req_d;
            bus.o_ray_ready   <= ready_d;
            bus.o_res_valid   <= res_valid_d;
            bus.o_hit         <= hit_d;
            bus.o_hit_idx     <= hit_idx_d;
            bus.o_hit_t       <= hit_t_d;
            bus.o_any_invalid <= any_inv_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        base_d      = base_q;
        idx_d       = idx_q;
        ray_d       = bus.o_isect_ray;
        tri_d       = bus.o_isect_tri;
        addr_d      = bus.o_tri_addr;
        tri_req_d   = 1'b0;
        res_valid_d = bus.o_res_valid;
        hit_d       = bus.o_hit;
        hit_idx_d   = bus.o_hit_idx;
        hit_t_d     = bus.o_hit_t;
        any_inv_d   = bus.o_any_invalid;

        unique case (state_q)
            S_IDLE: begin
                if (bus.i_ray_valid) begin
                    ray_d     = bus.i_ray;
                    num_d     = bus.i_num_tris;
                    base_d    = bus.i_base_addr;
                    idx_d     = '0;
                    hit_d     = 1'b0;
                    hit_idx_d = '0;
                    hit_t_d   = T_MAX;
                    any_inv_d = 1'b0;
                    addr_d    = bus.i_base_addr;
                    if (bus.i_num_tris == '0) begin
                        state_d     = S_DONE;
                        res_valid_d = 1'b1;
                    end else begin
                        state_d   = S_FETCH;
                        tri_req_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.i_tri_valid) begin
                    tri_d   = bus.i_tri;
                    state_d = S_TEST;
                end
            end
            S_TEST: begin
                if (bus.i_isect_invalid) begin
                    any_inv_d = 1'b1;
                end else if (closer) begin
                    hit_d     = 1'b1;
                    hit_idx_d = idx_q;
                    hit_t_d   = bus.i_isect_t;
                end
                if (idx_q == idx_last) begin
                    state_d     = S_DONE;
                    res_valid_d = 1'b1;
                end else begin
                    idx_d     = idx_inc;
                    // address wraps modulo 2^ADDR_W
                    addr_d    = ADDR_W'(base_q + ADDR_W'(idx_inc));
                    tri_req_d = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_DONE: begin
                if (bus.i_res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abort drops the job (and any pending record) from every busy state
        if (bus.i_abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            tri_req_d   = 1'b0;
            res_valid_d = 1'b0;
        end

        ready_d = (state_d == S_IDLE);
    end

endmodule

// File: tb/tb_ray_tri_scheduler.sv
// Self-checking bench for ray_tri_scheduler: the bench plays triangle memory
// (fixed extra latency), the intersect unit (verdict looked up from a tag in the
// triangle) and the result consumer, and checks against a list-level model.
module tb_ray_tri_scheduler;

    localparam int unsigned IDX_W  = 16;
    localparam int unsigned ADDR_W = 20;
    localparam int          MAX_T  = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ray_tri_scheduler_if #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) bus ();

    ray_tri_scheduler #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) dut (
        .i_clk  (clk),
        .i_rstn (rst_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic                  v_inv [MAX_T];
    logic                  v_res [MAX_T];
    logic signed [31:0]    v_t   [MAX_T];
    logic [2:0][2:0][31:0] tri_mem [MAX_T];
    logic [1:0][2:0][31:0] cur_ray;

    // intersect unit stand-in: verdict chosen by the tag held in corner 0, x lane
    assign bus.i_isect_invalid = v_inv[bus.o_isect_tri[0][0][5:0]];
    assign bus.i_isect_result  = v_res[bus.o_isect_tri[0][0][5:0]];
    assign bus.i_isect_t       = v_t[bus.o_isect_tri[0][0][5:0]];

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_ray_ready"}, 256'(bus.o_ray_ready), 256'(1));
        check_eq({pfx, "_tri_req"},   256'(bus.o_tri_req),   256'(0));
        check_eq({pfx, "_res_valid"}, 256'(bus.o_res_valid), 256'(0));
        check_eq({pfx, "_hit"},       256'(bus.o_hit),       256'(0));
        check_eq({pfx, "_any_inv"},   256'(bus.o_any_invalid), 256'(0));
        check_eq({pfx, "_hit_idx"},   256'(bus.o_hit_idx),   256'(0));
        check_eq({pfx, "_hit_t"},     256'(bus.o_hit_t),     256'(32'h7FFF_FFFF));
        check_eq({pfx, "_tri_addr"},  256'(bus.o_tri_addr),  256'(0));
        check_eq({pfx, "_isect_ray"}, 256'(bus.o_isect_ray), 256'(0));
        check_eq({pfx, "_isect_tri"}, 256'(bus.o_isect_tri), 256'(0));
    endtask

    task automatic fill_tris(input int n);
        for (int i = 0; i < n; i++) begin
            for (int a = 0; a < 3; a++)
                for (int b = 0; b < 3; b++)
                    tri_mem[i][a][b] = $urandom();
            tri_mem[i][0][0][15:0] = 16'(i);
        end
    endtask

    task automatic rand_ray();
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 3; b++)
                cur_ray[a][b] = $urandom();
    endtask

    // One job end to end; abort_req > 0 aborts in the WAIT after that request.
    task automatic run_job(input int n, input int lat, input logic [ADDR_W-1:0] base,
                           input int hold, input int abort_req);
        int k, reqs, pend, pidx, held, post, exp_lat;
        bit done, aborted, abort_arm, acked, seen;
        logic exp_hit, exp_inv;
        logic [IDX_W-1:0] exp_idx;
        logic signed [31:0] best;
        logic [ADDR_W-1:0] exp_addr;

        // reference: nearest valid hit over the list, ties keep the first
        exp_hit = 1'b0; exp_inv = 1'b0; exp_idx = '0; best = 32'sh7FFF_FFFF;
        for (int i = 0; i < n; i++) begin
            if (v_inv[i]) exp_inv = 1'b1;
            else if (v_res[i] && (v_t[i] < best)) begin
                best = v_t[i]; exp_idx = IDX_W'(i); exp_hit = 1'b1;
            end
        end
        exp_lat = n * (3 + lat) + 1;

        rand_ray();
        @(negedge clk);
        check_eq("ray_ready_offer", 256'(bus.o_ray_ready), 256'(1));
        bus.i_ray       = cur_ray;
        bus.i_num_tris  = IDX_W'(n);
        bus.i_base_addr = base;
        bus.i_ray_valid = 1'b1;

        k = 0; reqs = 0; pend = 0; pidx = 0; held = 0; post = 0;
        done = 0; aborted = 0; abort_arm = 0; acked = 0; seen = 0;
        while (!done) begin
            @(negedge clk);
            k++;
            bus.i_ray_valid = 1'b0;
            bus.i_tri_valid = 1'b0;
            if (k > 2000) begin
                check_eq("job_timeout", 256'(k), 256'(exp_lat));
                break;
            end
            if (abort_arm) begin
                bus.i_abort = 1'b1;
                abort_arm   = 0;
            end else if (bus.i_abort) begin
                bus.i_abort = 1'b0;
                aborted     = 1;
                post        = k;
            end

            if (aborted) begin
                check_eq("abort_no_result", 256'(bus.o_res_valid), 256'(0));
                check_eq("abort_no_req",    256'(bus.o_tri_req),   256'(0));
                if (k == post) check_eq("abort_ray_ready", 256'(bus.o_ray_ready), 256'(1));
                if (k == post + 6) begin
                    check_eq("abort_req_count", 256'(reqs), 256'(abort_req));
                    done = 1;
                end
            end else if (acked) begin
                bus.i_res_ready = 1'b0;
                check_eq("res_valid_after_ack", 256'(bus.o_res_valid), 256'(0));
                check_eq("ray_ready_after_ack", 256'(bus.o_ray_ready), 256'(1));
                done = 1;
            end else begin
                check_eq("ray_ready_busy", 256'(bus.o_ray_ready), 256'(0));
                check_eq("isect_ray_held", 256'(bus.o_isect_ray), 256'(cur_ray));
                if (bus.o_res_valid) begin
                    if (!seen) begin
                        seen = 1;
                        check_eq("job_latency", 256'(k), 256'(exp_lat));
                        check_eq("req_count",   256'(reqs), 256'(n));
                    end
                    check_eq("res_hit",     256'(bus.o_hit),         256'(exp_hit));
                    check_eq("res_hit_t",   256'(bus.o_hit_t),       256'(best));
                    check_eq("res_any_inv", 256'(bus.o_any_invalid), 256'(exp_inv));
                    if (exp_hit) check_eq("res_hit_idx", 256'(bus.o_hit_idx), 256'(exp_idx));
                    if (held >= hold) begin
                        bus.i_res_ready = 1'b1;
                        acked = 1;
                    end else begin
                        bus.i_res_ready = 1'b0;
                    end
                    held++;
                end
            end

            // memory: data valid for one cycle, lat cycles after the first WAIT cycle
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.i_tri_valid = 1'b1;
                    bus.i_tri       = tri_mem[pidx];
                end
            end
            if (bus.o_tri_req && !aborted) begin
                exp_addr = ADDR_W'(base + ADDR_W'(reqs));
                check_eq("tri_addr", 256'(bus.o_tri_addr), 256'(exp_addr));
                pidx = reqs;
                reqs++;
                pend = lat + 1;
                if (reqs == abort_req) abort_arm = 1;
            end
        end
        bus.i_abort     = 1'b0;
        bus.i_res_ready = 1'b0;
        bus.i_tri_valid = 1'b0;
    endtask

    initial begin
        bit seen_req;
        int n;

        bus.i_ray_valid = 1'b0; bus.i_ray = '0; bus.i_num_tris = '0; bus.i_base_addr = '0;
        bus.i_abort = 1'b0; bus.i_tri_valid = 1'b0; bus.i_tri = '0; bus.i_res_ready = 1'b0;
        for (int i = 0; i < MAX_T; i++) begin
            v_inv[i] = 1'b0; v_res[i] = 1'b0; v_t[i] = '0; tri_mem[i] = '0;
        end

        repeat (2) @(negedge clk);
        check_reset_vals("por");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("idle");

        // reset in the middle of WAIT, then a stale memory response
        fill_tris(3);
        rand_ray();
        bus.i_ray = cur_ray; bus.i_num_tris = 16'd3; bus.i_base_addr = 20'h00100;
        bus.i_ray_valid = 1'b1;
        seen_req = 0;
        for (int k = 0; k < 20 && !seen_req; k++) begin
            @(negedge clk);
            bus.i_ray_valid = 1'b0;
            if (bus.o_tri_req) seen_req = 1;
        end
        check_eq("rst_req_seen", 256'(seen_req), 256'(1));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_tri_valid = 1'b1;
        bus.i_tri = tri_mem[0];
        @(negedge clk);
        bus.i_tri_valid = 1'b0;
        check_reset_vals("rst_stale");
        @(negedge clk);
        check_reset_vals("rst_stale2");

        // N=3 hits 5,3,3: tie keeps index 1
        fill_tris(3);
        for (int i = 0; i < 3; i++) begin v_inv[i] = 1'b0; v_res[i] = 1'b1; end
        v_t[0] = 32'sd5; v_t[1] = 32'sd3; v_t[2] = 32'sd3;
        run_job(3, 1, 20'h00010, 0, 0);

        // empty list
        run_job(0, 1, 20'h00ABC, 1, 0);

        // invalid test discarded, second misses
        fill_tris(2);
        v_inv[0] = 1'b1; v_res[0] = 1'b1; v_t[0] = 32'sd1;
        v_inv[1] = 1'b0; v_res[1] = 1'b0; v_t[1] = 32'sd2;
        run_job(2, 0, 20'h00200, 0, 0);

        // address wrap
        fill_tris(2);
        v_inv[0] = 1'b0; v_res[0] = 1'b1; v_t[0] = -32'sd7;
        v_inv[1] = 1'b0; v_res[1] = 1'b1; v_t[1] = 32'sd9;
        run_job(2, 2, 20'hFFFFF, 0, 0);

        // abort in the second WAIT, then a job with a slow consumer
        fill_tris(4);
        for (int i = 0; i < 4; i++) begin v_inv[i] = 1'b0; v_res[i] = 1'b1; v_t[i] = 32'(10 - i); end
        run_job(4, 1, 20'h00300, 0, 2);
        fill_tris(3);
        v_inv[0] = 1'b0; v_res[0] = 1'b1; v_t[0] = 32'sd8;
        v_inv[1] = 1'b1; v_res[1] = 1'b1; v_t[1] = -32'sd50;
        v_inv[2] = 1'b0; v_res[2] = 1'b1; v_t[2] = -32'sd4;
        run_job(3, 2, 20'h00400, 5, 0);

        // randomized jobs
        for (int j = 0; j < 30; j++) begin
            n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            fill_tris(n);
            for (int i = 0; i < n; i++) begin
                v_inv[i] = ($urandom_range(0, 5) == 0);
                v_res[i] = 1'($urandom_range(0, 1));
                v_t[i]   = $signed(32'($urandom_range(0, 40))) - 32'sd20;
            end
            run_job(n, int'($urandom_range(0, 3)), ADDR_W'($urandom()),
                    int'($urandom_range(0, 3)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
